// File: rtl/batch_3_div_seq.sv
// Sequential restoring divider: 34-bit signed dividend by 9-bit unsigned divisor,
// saturated 25-bit signed quotient plus signed remainder, ap_start/ap_done handshake.
module batch_3_div_seq #(
   parameter logic [31:0] ID         = 32'd1,
   parameter int          din0_WIDTH = 34,
   parameter int          din1_WIDTH = 9,
   parameter int          dout_WIDTH = 25
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  ap_start,
   output logic                  ap_ready,
   output logic                  ap_idle,
   output logic                  ap_done,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic [dout_WIDTH-1:0] dout,
   output logic [9:0]            rem,
   output logic                  ovf,
   output logic                  dbz
);

   if (din0_WIDTH != 34 || din1_WIDTH != 9 || dout_WIDTH != 25) begin : g_bad_width
      $error("batch_3_div_seq instance %0d: only 34/9/25 widths are supported", ID);
   end

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

   state_t       state, state_nxt;
   logic [33:0]  dq;        // dividend bits shift out of the top, quotient bits in at the bottom
   logic [8:0]   dvs;
   logic [9:0]   pr;
   logic [5:0]   cnt;
   logic         neg, nz, done_r;

   logic [9:0]   shifted, pr_nxt;
   logic         qbit;
   logic [24:0]  dout_n;
   logic [9:0]   rem_n;
   logic         ovf_n, dbz_n;

   assign ap_idle  = (state == S_IDLE);
   assign ap_ready = ap_start & (state == S_IDLE);
   assign ap_done  = done_r;

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) state <= S_IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (ap_start) state_nxt = S_CALC;
         S_CALC:   if (cnt == 6'd0) state_nxt = S_FINISH;
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // pr < divisor <= 511, so bit 9 is always clear before the shift.
   always_comb begin
      shifted = {pr[8:0], dq[33]};
      qbit    = (shifted >= {1'b0, dvs});
      pr_nxt  = qbit ? (shifted - {1'b0, dvs}) : shifted;
   end

   always_comb begin
      dout_n = '0;
      rem_n  = '0;
      ovf_n  = 1'b0;
      dbz_n  = 1'b0;
      if (dvs == 9'd0) begin
         dbz_n  = 1'b1;
         ovf_n  = 1'b1;
         dout_n = neg ? 25'h1000000 : (nz ? 25'h0FFFFFF : 25'h0000000);
      end else if (neg) begin
         rem_n = -pr;
         if (dq > 34'h001000000) begin
            dout_n = 25'h1000000;
            ovf_n  = 1'b1;
         end else begin
            dout_n = -dq[24:0];
         end
      end else begin
         rem_n = pr;
         if (dq > 34'h000FFFFFF) begin
            dout_n = 25'h0FFFFFF;
            ovf_n  = 1'b1;
         end else begin
            dout_n = dq[24:0];
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         dq     <= '0;
         dvs    <= '0;
         pr     <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         nz     <= 1'b0;
         done_r <= 1'b0;
         dout   <= '0;
         rem    <= '0;
         ovf    <= 1'b0;
         dbz    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ap_start) begin
                  neg <= din0[33];
                  nz  <= |din0;
                  dq  <= din0[33] ? 34'(-din0) : din0;
                  dvs <= din1;
                  pr  <= '0;
                  cnt <= 6'd33;
               end
            end
            S_CALC: begin
               pr <= pr_nxt;
               dq <= {dq[32:0], qbit};
               if (cnt != 6'd0) cnt <= cnt - 6'd1;
            end
            S_FINISH: begin
               dout   <= dout_n;
               rem    <= rem_n;
               ovf    <= ovf_n;
               dbz    <= dbz_n;
               done_r <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_batch_3_div_seq.sv
// Directed bench for batch_3_div_seq: hand-computed quotients, saturation,
// divide-by-zero, back-to-back starts and reset abort.
module tb_batch_3_div_seq;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n, ap_start;
   logic        ap_ready, ap_idle, ap_done;
   logic [33:0] din0;
   logic [8:0]  din1;
   logic [24:0] dout;
   logic [9:0]  rem;
   logic        ovf, dbz;

   int compared   = 0;
   int mismatched = 0;

   always #5 ap_clk = ~ap_clk;

   batch_3_div_seq #(.ID(32'd1)) dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .ap_start (ap_start),
      .ap_ready (ap_ready),
      .ap_idle  (ap_idle),
      .ap_done  (ap_done),
      .din0     (din0),
      .din1     (din1),
      .dout     (dout),
      .rem      (rem),
      .ovf      (ovf),
      .dbz      (dbz)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic accept(input string tag, input logic [33:0] a, input logic [8:0] b);
      @(negedge ap_clk);
      din0     = a;
      din1     = b;
      ap_start = 1'b1;
      #1 chk({tag, ".ready"}, 64'(ap_ready), 64'd1);
      @(posedge ap_clk);
      #1;
   endtask

   task automatic wait_done(input string tag, input logic [24:0] ed, input logic [9:0] er,
                            input logic eo, input logic ez);
      int          n;
      int          busy_bad;
      logic [24:0] d_prev;
      logic [9:0]  r_prev;
      n        = 0;
      busy_bad = 0;
      d_prev   = dout;
      r_prev   = rem;
      @(negedge ap_clk);
      while (ap_done !== 1'b1 && n < 60) begin
         if (ap_idle !== 1'b0 || ap_ready !== 1'b0 || dout !== d_prev || rem !== r_prev)
            busy_bad++;
         @(negedge ap_clk);
         n++;
      end
      chk({tag, ".latency"}, 64'(n), 64'd35);
      chk({tag, ".busy"}, 64'(busy_bad), 64'd0);
      chk({tag, ".dout"}, 64'(dout), 64'(ed));
      chk({tag, ".rem"}, 64'(rem), 64'(er));
      chk({tag, ".ovf"}, 64'(ovf), 64'(eo));
      chk({tag, ".dbz"}, 64'(dbz), 64'(ez));
      chk({tag, ".idle"}, 64'(ap_idle), 64'd1);
   endtask

   task automatic do_op(input string tag, input logic [33:0] a, input logic [8:0] b,
                        input logic [24:0] ed, input logic [9:0] er, input logic eo, input logic ez);
      accept(tag, a, b);
      ap_start = 1'b0;
      din0     = {$urandom, $urandom};
      din1     = 9'($urandom);
      wait_done(tag, ed, er, eo, ez);
      @(negedge ap_clk);
      chk({tag, ".pulse"}, 64'(ap_done), 64'd0);
      chk({tag, ".hold"}, 64'(dout), 64'(ed));
   endtask

   initial begin
      int ndone;
      ap_rst_n = 1'b0;
      ap_start = 1'b1;
      din0     = 34'd1000;
      din1     = 9'd7;
      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      chk("rst.dout", 64'(dout), 64'd0);
      chk("rst.rem", 64'(rem), 64'd0);
      chk("rst.ovf", 64'(ovf), 64'd0);
      chk("rst.dbz", 64'(dbz), 64'd0);
      chk("rst.done", 64'(ap_done), 64'd0);
      chk("rst.idle", 64'(ap_idle), 64'd1);
      ap_start = 1'b0;
      ap_rst_n = 1'b1;

      do_op("pos",      34'd1000,           9'd7,   25'd142,       10'd6,    1'b0, 1'b0);
      do_op("neg",      -34'sd1000,         9'd7,   25'h1FFFF72,   10'h3FA,  1'b0, 1'b0);
      do_op("minneg",   34'h200000000,      9'd1,   25'h1000000,   10'd0,    1'b1, 1'b0);
      do_op("maxpos",   34'h1FFFFFFFF,      9'd511, 25'h0FFFFFF,   10'd63,   1'b1, 1'b0);
      do_op("dbzpos",   34'd5,              9'd0,   25'h0FFFFFF,   10'd0,    1'b1, 1'b1);
      do_op("dbzneg",   -34'sd5,            9'd0,   25'h1000000,   10'd0,    1'b1, 1'b1);
      do_op("dbzzero",  34'd0,              9'd0,   25'd0,         10'd0,    1'b1, 1'b1);
      do_op("negedge",  -34'sd16777216,     9'd1,   25'h1000000,   10'd0,    1'b0, 1'b0);
      do_op("posedge",  34'd16777215,       9'd1,   25'h0FFFFFF,   10'd0,    1'b0, 1'b0);
      do_op("possat",   34'd16777216,       9'd1,   25'h0FFFFFF,   10'd0,    1'b1, 1'b0);
      do_op("zero",     34'd0,              9'd3,   25'd0,         10'd0,    1'b0, 1'b0);
      do_op("negone",   -34'sd7,            9'd7,   25'h1FFFFFF,   10'd0,    1'b0, 1'b0);
      do_op("negsmall", -34'sd510,          9'd511, 25'd0,         10'h202,  1'b0, 1'b0);
      do_op("negodd",   -34'sd7,            9'd2,   25'h1FFFFFD,   10'h3FF,  1'b0, 1'b0);
      do_op("big",      34'd123456789,      9'd300, 25'd411522,    10'd189,  1'b0, 1'b0);

      // back-to-back: start held high, operands change right after each acceptance
      accept("b2b0", 34'd100, 9'd3);
      din0 = 34'd200;
      din1 = 9'd9;
      wait_done("b2b0", 25'd33, 10'd1, 1'b0, 1'b0);
      chk("b2b0.rearm", 64'(ap_ready), 64'd1);
      @(posedge ap_clk);
      #1;
      din0     = 34'd7;
      din1     = 9'd1;
      ap_start = 1'b0;
      wait_done("b2b1", 25'd22, 10'd2, 1'b0, 1'b0);

      // reset abort in the middle of CALC
      do_op("preabort", 34'd5, 9'd0, 25'h0FFFFFF, 10'd0, 1'b1, 1'b1);
      accept("abort", 34'd1000, 9'd7);
      ap_start = 1'b0;
      repeat (20) @(negedge ap_clk);
      ap_rst_n = 1'b0;
      @(negedge ap_clk);
      chk("abort.dout", 64'(dout), 64'd0);
      chk("abort.ovf", 64'(ovf), 64'd0);
      chk("abort.dbz", 64'(dbz), 64'd0);
      chk("abort.idle", 64'(ap_idle), 64'd1);
      ap_rst_n = 1'b1;
      ndone = 0;
      repeat (45) begin
         @(negedge ap_clk);
         if (ap_done === 1'b1) ndone++;
      end
      chk("abort.nodone", 64'(ndone), 64'd0);
      do_op("postabort", 34'd1000, 9'd7, 25'd142, 10'd6, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
